serial_magnitude_comparator: RTL

//   Sequential, bit-serial counterpart to the parallel cascaded comparator.

---
 rtl/serial_magnitude_comparator.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: latches two LEN-bit operands on start and
// scans them LSB first, one bit per clock, reporting less/equal/great on done.
module serial_magnitude_comparator #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    output logic           busy,
    output logic           done,
    output logic           less_out,
    output logic           equal_out,
    output logic           great_out
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [LEN-1:0]   shiftA_q;
    logic [LEN-1:0]   shiftB_q;
    logic [CNT_W-1:0] bitCount_q;
    logic             lt_q;
    logic             gt_q;
    logic             lt_d;
    logic             gt_d;
    logic             busy_q;
    logic             done_q;
    logic             less_q;
    logic             equal_q;
    logic             great_q;

    // A differing bit always wins because later (more significant) bits are seen last.
    always_comb begin
        lt_d = lt_q;
        gt_d = gt_q;
        if (shiftA_q[0] && !shiftB_q[0]) begin
            gt_d = 1'b1;
            lt_d = 1'b0;
        end else if (!shiftA_q[0] && shiftB_q[0]) begin
            lt_d = 1'b1;
            gt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftA_q   <= '0;
            shiftB_q   <= '0;
            bitCount_q <= '0;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            less_q     <= 1'b0;
            equal_q    <= 1'b1;
            great_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        shiftA_q   <= a;
                        shiftB_q   <= b;
                        lt_q       <= 1'b0;
                        gt_q       <= 1'b0;
                        bitCount_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    lt_q       <= lt_d;
                    gt_q       <= gt_d;
                    shiftA_q   <= shiftA_q >> 1;
                    shiftB_q   <= shiftB_q >> 1;
                    bitCount_q <= bitCount_q + CNT_W'(1);
                    if (bitCount_q == LAST_BIT) begin
                        less_q  <= lt_d;
                        great_q <= gt_d;
                        equal_q <= ~(lt_d | gt_d);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign less_out  = less_q;
    assign equal_out = equal_q;
    assign great_out = great_q;

endmodule
